robo_controller: RTL
====================

// Module: robo_controller
// PURPOSE
//  Navigation FSM that drives the maze-memory/robot model from upstream.
//  - Consumes the four sensor flags (head, left, under, barrier).
//  - Issues avancar / girar / remover commands using a left-hand wall-follower
//    with barrier removal.
//  - Stops on the black exit cell and reports done, or reports fail on move
//    budget exhaustion or boxed-in detection.
// PARAMETERS
//  MAX_MOVES      1023  forward moves allowed before fail; move_count width is 10
//  REMOVE_CYCLES  3     consecutive remover cycles the memory needs per barrier level
//  TURN_R_CYCLES  3     consecutive girar cycles forming one right turn (girar = 90 deg CCW)
//  MAX_SPIN       4     consecutive right turns with no advance before fail
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  iniciar     in   1   start request, sampled only in IDLE
//  head_in     in   1   1 = wall/edge ahead
//  left_in     in   1   1 = wall/edge on the left
//  under_in    in   1   1 = robot on the BLACK (exit) cell
//  barrier_in  in   1   1 = barrier cell ahead
//  avancar     out  1   advance one cell (registered)
//  girar       out  1   rotate 90 deg CCW per cycle high (registered)
//  remover     out  1   barrier hit, counted by memory while high (registered)
//  done        out  1   exit reached, sticky
//  fail        out  1   budget exhausted or boxed in, sticky
//  move_count  out  10  forward moves issued since start
// BEHAVIOUR
//  Reset (reset=0, async)
//   - State goes to IDLE.
//   - All outputs clear to 0; move_count=0.
//   - turned_left, spin_cnt and phase counter clear to 0.
//  Command rule: at most one of avancar/girar/remover is high in any cycle.
//  States and transitions
//   - IDLE: iniciar=1 -> SENSE.
//   - SENSE: one cycle, decides from sensors in this priority order:
//     1. under_in=1 -> DONE
//     2. left_in=0 and turned_left=0 -> TURN_L
//     3. head_in=0 and barrier_in=0 -> FWD
//     4. barrier_in=1 -> REMOVE
//     5. otherwise -> TURN_R
//   - TURN_L: girar=1 for 1 cycle; sets turned_left=1 -> SETTLE.
//   - FWD: avancar=1 for 1 cycle; turned_left=0, spin_cnt=0, move_count+1 -> SETTLE.
//   - REMOVE: remover=1 for exactly REMOVE_CYCLES consecutive cycles -> SETTLE.
//     A BARRIER9 therefore takes 3 REMOVE visits.
//   - TURN_R: girar=1 for TURN_R_CYCLES consecutive cycles; turned_left=0,
//     spin_cnt+1 -> SETTLE.
//   - SETTLE: all commands 0 for 1 cycle so memory outputs re-settle -> SENSE.
//     If spin_cnt==MAX_SPIN or move_count==MAX_MOVES, go to FAIL instead.
//   - DONE / FAIL: terminal; commands 0, flag held until reset.
//  Latency: commands are registered and appear the cycle after the SENSE decision.
//  move_count never wraps; it freezes once FAIL is entered.
//  iniciar changes outside IDLE are ignored.
//  Reset mid-command drops every output on the reset edge. No partial remover
//   burst continues after reset; the memory's own counter is reset by its reset.
//  Sensors are sampled only in SENSE; glitches in other states have no effect.
// TESTING
//  1. Reset low, then iniciar=1 with head=0, left=1, barrier=0, under=0
//     -> avancar high exactly 1 cycle; move_count=1; SETTLE; SENSE.
//  2. left=0 at first SENSE, then left=0 and head=0
//     -> one girar pulse, then avancar. No second left turn (turned_left blocks it).
//  3. head=0, barrier=1, left=1
//     -> remover high exactly 3 cycles, 1 idle cycle, re-SENSE.
//     Barrier held 3 SENSE visits -> 9 remover cycles total.
//  4. head=1, left=1, barrier=0, held constant
//     -> girar bursts of 3; after the 4th burst fail=1, all commands stay 0.
//  5. under=1 at any SENSE -> done=1 the next cycle, no command issued, holds.
//     Then reset=0 -> done=0, IDLE.
//  6. MAX_MOVES=5, head=0 constant -> 5 avancar pulses, then fail=1,
//     move_count=5. Check pairwise mutual exclusion of commands throughout.

Source files
------------

// File: rtl/robo_if.sv
// Sensor/command bundle between the maze-memory/robot model and the navigation FSM.
//   master : upstream side, drives iniciar and the four sensor flags, observes commands/status
//   slave  : robo_controller side, consumes sensors, drives avancar/girar/remover, done/fail, move_count
interface robo_if;
  logic       iniciar;
  logic       head_in;
  logic       left_in;
  logic       under_in;
  logic       barrier_in;
  logic       avancar;
  logic       girar;
  logic       remover;
  logic       done;
  logic       fail;
  logic [9:0] move_count;

  modport master (
    output iniciar, head_in, left_in, under_in, barrier_in,
    input  avancar, girar, remover, done, fail, move_count
  );

  modport slave (
    input  iniciar, head_in, left_in, under_in, barrier_in,
    output avancar, girar, remover, done, fail, move_count
  );
endinterface

// File: rtl/robo_controller.sv
// Left-hand wall-follower navigation FSM with barrier removal.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : robo_if.slave -- iniciar + sensors in; avancar/girar/remover,
//            done/fail (sticky) and move_count out, all registered
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for iniciar
// SENSE   | one-cycle decision from the sensor flags
// TURN_L  | single girar cycle (90 deg CCW = left turn)
// FWD     | single avancar cycle
// REMOVE  | remover burst of REMOVE_CYCLES cycles
// TURN_R  | girar burst of TURN_R_CYCLES cycles (270 deg CCW = right turn)
// SETTLE  | commands idle for one cycle; budget / spin checks
// DONE    | exit cell reached, terminal
// FAIL    | move budget exhausted or boxed in, terminal
module robo_controller #(
  parameter int MAX_MOVES     = 1023,
  parameter int REMOVE_CYCLES = 3,
  parameter int TURN_R_CYCLES = 3,
  parameter int MAX_SPIN      = 4
) (
  input logic  clock,
  input logic  reset,
  robo_if.slave bus
);

  localparam int PH_MAX = (REMOVE_CYCLES > TURN_R_CYCLES) ? REMOVE_CYCLES : TURN_R_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int SP_W   = $clog2(MAX_SPIN + 1);

  localparam logic [PH_W-1:0] REM_LOAD  = PH_W'(REMOVE_CYCLES - 1);
  localparam logic [PH_W-1:0] TURN_LOAD = PH_W'(TURN_R_CYCLES - 1);
  localparam logic [SP_W-1:0] SPIN_MAX  = SP_W'(MAX_SPIN);
  localparam logic [9:0]      MOVE_MAX  = 10'(MAX_MOVES);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SENSE, ST_TURN_L, ST_FWD, ST_REMOVE,
    ST_TURN_R, ST_SETTLE, ST_DONE, ST_FAIL
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase;
  logic [SP_W-1:0] spin_cnt;
  logic            turned_left;
  logic            avancar_q, girar_q, remover_q, done_q, fail_q;
  logic [9:0]      move_count_q;

  assign bus.avancar    = avancar_q;
  assign bus.girar      = girar_q;
  assign bus.remover    = remover_q;
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.move_count = move_count_q;

  // Commands are loaded on the edge that leaves SENSE so they line up with
  // the command state itself; phase is a down-counter ending at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      phase        <= '0;
      spin_cnt     <= '0;
      turned_left  <= 1'b0;
      avancar_q    <= 1'b0;
      girar_q      <= 1'b0;
      remover_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      move_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.iniciar) state <= ST_SENSE;
        end
        ST_SENSE: begin
          if (bus.under_in) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else if (!bus.left_in && !turned_left) begin
            state       <= ST_TURN_L;
            girar_q     <= 1'b1;
            turned_left <= 1'b1;
          end else if (!bus.head_in && !bus.barrier_in) begin
            state        <= ST_FWD;
            avancar_q    <= 1'b1;
            turned_left  <= 1'b0;
            spin_cnt     <= '0;
            move_count_q <= move_count_q + 10'd1;
          end else if (bus.barrier_in) begin
            state     <= ST_REMOVE;
            remover_q <= 1'b1;
            phase     <= REM_LOAD;
          end else begin
            state       <= ST_TURN_R;
            girar_q     <= 1'b1;
            phase       <= TURN_LOAD;
            turned_left <= 1'b0;
            spin_cnt    <= spin_cnt + 1'b1;
          end
        end
        ST_TURN_L, ST_FWD: begin
          girar_q   <= 1'b0;
          avancar_q <= 1'b0;
          state     <= ST_SETTLE;
        end
        ST_REMOVE: begin
          if (phase == '0) begin
            remover_q <= 1'b0;
            state     <= ST_SETTLE;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_TURN_R: begin
          if (phase == '0) begin
            girar_q <= 1'b0;
            state   <= ST_SETTLE;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_SETTLE: begin
          // Both limits are checked here so move_count can never pass MOVE_MAX.
          if (spin_cnt == SPIN_MAX || move_count_q == MOVE_MAX) begin
            state  <= ST_FAIL;
            fail_q <= 1'b1;
          end else begin
            state <= ST_SENSE;
          end
        end
        ST_DONE, ST_FAIL: begin
          state <= state;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
